// File: rtl/change_dispense.sv
// change_dispense: computes change (total - price) after a vend and pays it out
// one coin at a time, largest denomination first, limited by per-tube stock.
// Coin handshake: coin_valid/coin_sel are presented in ISSUE and held stable
// until a cycle with coin_ready=1; the coin is considered taken on that edge.
// coin_ready while coin_valid=0 has no effect.
module change_dispense #(
    parameter int CURRENCY_WIDTH = 7,
    parameter int STOCK_WIDTH    = 6,
    parameter int DENOM_0        = 25,
    parameter int DENOM_1        = 10,
    parameter int DENOM_2        = 5,
    parameter int DENOM_3        = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      change_req,
    input  logic [CURRENCY_WIDTH-1:0] total_currency,
    input  logic [CURRENCY_WIDTH-1:0] item_price,
    output logic                      coin_valid,
    output logic [1:0]                coin_sel,
    input  logic                      coin_ready,
    input  logic                      refill_valid,
    input  logic [1:0]                refill_sel,
    input  logic [STOCK_WIDTH-1:0]    refill_count,
    output logic                      change_busy,
    output logic                      change_done,
    output logic                      change_err,
    output logic                      change_short,
    output logic [CURRENCY_WIDTH-1:0] change_remaining,
    output logic [3:0]                stock_empty
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [STOCK_WIDTH:0] STOCK_MAX = {1'b0, {STOCK_WIDTH{1'b1}}};

    // Tube value lookup; tube 0 is the largest coin.
    function automatic logic [CURRENCY_WIDTH-1:0] denom(input logic [1:0] idx);
        case (idx)
            2'd0:    denom = CURRENCY_WIDTH'(DENOM_0);
            2'd1:    denom = CURRENCY_WIDTH'(DENOM_1);
            2'd2:    denom = CURRENCY_WIDTH'(DENOM_2);
            default: denom = CURRENCY_WIDTH'(DENOM_3);
        endcase
    endfunction

    state_t                    state_q, state_d;
    logic [CURRENCY_WIDTH-1:0] remaining_q, remaining_d;
    logic [1:0]                coin_sel_q, coin_sel_d;
    logic                      err_q, err_d;
    logic                      short_q, short_d;
    logic [STOCK_WIDTH-1:0]    stock_q [4];
    logic [STOCK_WIDTH-1:0]    stock_d [4];

    logic                      pick_found;
    logic [1:0]                pick_idx;
    logic                      coin_taken;

    assign coin_taken = (state_q == ISSUE) && coin_ready;

    // Greedy pick: lowest tube index whose coin fits the remainder and is in stock.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if ((denom(2'(i)) <= remaining_q) && (stock_q[i] != '0)) begin
                pick_found = 1'b1;
                pick_idx   = 2'(i);
            end
        end
    end

    // Stock bookkeeping: refill and coin payout may hit the same tube in one cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic [STOCK_WIDTH:0] sum;
            sum = {1'b0, stock_q[i]};
            if (refill_valid && (refill_sel == 2'(i))) begin
                sum = sum + {1'b0, refill_count};
            end
            // A tube is only selected when non-empty, so this never goes negative.
            if (coin_taken && (coin_sel_q == 2'(i))) begin
                sum = sum - 1'b1;
            end
            stock_d[i] = (sum > STOCK_MAX) ? STOCK_MAX[STOCK_WIDTH-1:0] : sum[STOCK_WIDTH-1:0];
        end
    end

    // Next-state logic for the payout sequencer.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_sel_d  = coin_sel_q;
        err_d       = err_q;
        short_d     = short_q;
        case (state_q)
            IDLE: begin
                if (change_req) begin
                    short_d = 1'b0;
                    if (total_currency >= item_price) begin
                        remaining_d = total_currency - item_price;
                        err_d       = 1'b0;
                        state_d     = SELECT;
                    end else begin
                        remaining_d = '0;
                        err_d       = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            SELECT: begin
                if (remaining_q == '0) begin
                    state_d = DONE;
                end else if (pick_found) begin
                    coin_sel_d = pick_idx;
                    state_d    = ISSUE;
                end else begin
                    short_d = 1'b1;
                    state_d = DONE;
                end
            end
            ISSUE: begin
                if (coin_ready) begin
                    remaining_d = remaining_q - denom(coin_sel_q);
                    state_d     = SELECT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset also empties every tube.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            coin_sel_q  <= 2'd0;
            err_q       <= 1'b0;
            short_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_sel_q  <= coin_sel_d;
            err_q       <= err_d;
            short_q     <= short_d;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        coin_valid       = (state_q == ISSUE);
        coin_sel         = coin_sel_q;
        change_busy      = (state_q != IDLE);
        change_done      = (state_q == DONE);
        change_err       = err_q;
        change_short     = short_q;
        change_remaining = remaining_q;
        for (int i = 0; i < 4; i++) begin
            stock_empty[i] = (stock_q[i] == '0);
        end
    end

endmodule

// File: tb/tb_change_dispense.sv
// Directed bench for change_dispense: expected coin order goes into exp_q,
// a monitor pops it on every accepted coin, done/flags are checked per request.
module tb_change_dispense;

    logic       clk = 1'b0;
    logic       rst;
    logic       change_req;
    logic [6:0] total_currency;
    logic [6:0] item_price;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       coin_ready;
    logic       refill_valid;
    logic [1:0] refill_sel;
    logic [5:0] refill_count;
    logic       change_busy;
    logic       change_done;
    logic       change_err;
    logic       change_short;
    logic [6:0] change_remaining;
    logic [3:0] stock_empty;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int valid_cnt = 0;
    int done_cnt  = 0;
    logic [1:0] exp_q[$];

    change_dispense dut (
        .clk              (clk),
        .rst              (rst),
        .change_req       (change_req),
        .total_currency   (total_currency),
        .item_price       (item_price),
        .coin_valid       (coin_valid),
        .coin_sel         (coin_sel),
        .coin_ready       (coin_ready),
        .refill_valid     (refill_valid),
        .refill_sel       (refill_sel),
        .refill_count     (refill_count),
        .change_busy      (change_busy),
        .change_done      (change_done),
        .change_err       (change_err),
        .change_short     (change_short),
        .change_remaining (change_remaining),
        .stock_empty      (stock_empty)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // scoreboard: every accepted coin must match the next expected tube
    always @(negedge clk) begin
        if (!rst) begin
            if (coin_valid) valid_cnt++;
            if (change_done) done_cnt++;
            if (coin_valid && coin_ready) begin
                if (exp_q.size() == 0) check("extra_coin", 32'd1, 32'd0);
                else check("coin_sel", 32'(coin_sel), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic refill(input logic [1:0] sel, input logic [5:0] cnt);
        refill_valid = 1'b1;
        refill_sel   = sel;
        refill_count = cnt;
        @(posedge clk); #1;
        refill_valid = 1'b0;
    endtask

    task automatic start_req(input logic [6:0] tot, input logic [6:0] pr);
        total_currency = tot;
        item_price     = pr;
        change_req     = 1'b1;
        @(posedge clk); #1;
        change_req = 1'b0;
    endtask

    // lat counts cycles after the accepting edge; -1 means no done pulse seen
    task automatic wait_done(output int lat, output logic e, output logic s, output logic [6:0] r);
        lat = -1; e = 1'b0; s = 1'b0; r = '0;
        for (int k = 1; k <= 200; k++) begin
            if (change_done) begin
                lat = k; e = change_err; s = change_short; r = change_remaining;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (coin_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    int         lat;
    logic       e, s, ok;
    logic [6:0] r;
    int         v0, d0;

    initial begin
        rst = 1'b1; change_req = 1'b0; total_currency = '0; item_price = '0;
        coin_ready = 1'b1; refill_valid = 1'b0; refill_sel = '0; refill_count = '0;
        do_reset();

        check("rst_valid", 32'(coin_valid), 32'd0);
        check("rst_busy", 32'(change_busy), 32'd0);
        check("rst_done", 32'(change_done), 32'd0);
        check("rst_sel", 32'(coin_sel), 32'd0);
        check("rst_rem", 32'(change_remaining), 32'd0);
        check("rst_empty", 32'(stock_empty), 32'hF);

        // change 40 from full tubes: 25, 10, 5
        for (int i = 0; i < 4; i++) refill(2'(i), 6'd10);
        check("refill_empty", 32'(stock_empty), 32'h0);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        start_req(7'd65, 7'd25);
        check("t1_busy", 32'(change_busy), 32'd1);
        wait_done(lat, e, s, r);
        check("t1_lat", 32'(lat), 32'd8);
        check("t1_err", 32'(e), 32'd0);
        check("t1_short", 32'(s), 32'd0);
        check("t1_rem", 32'(r), 32'd0);
        @(posedge clk); #1;
        check("t1_idle", 32'(change_busy), 32'd0);
        check("t1_empty", 32'(stock_empty), 32'h0);

        // exact change
        v0 = valid_cnt;
        start_req(7'd30, 7'd30);
        wait_done(lat, e, s, r);
        check("t2_lat", 32'(lat), 32'd2);
        check("t2_err", 32'(e), 32'd0);
        check("t2_short", 32'(s), 32'd0);
        check("t2_rem", 32'(r), 32'd0);
        check("t2_novalid", 32'(valid_cnt - v0), 32'd0);
        @(posedge clk); #1;

        // price above total
        v0 = valid_cnt;
        start_req(7'd20, 7'd30);
        wait_done(lat, e, s, r);
        check("t3_lat", 32'(lat), 32'd1);
        check("t3_err", 32'(e), 32'd1);
        check("t3_short", 32'(s), 32'd0);
        check("t3_rem", 32'(r), 32'd0);
        check("t3_novalid", 32'(valid_cnt - v0), 32'd0);
        @(posedge clk); #1;

        // short stock 0/1/0/2, change 14: 10, 1, 1, then stuck at 2
        do_reset();
        refill(2'd1, 6'd1);
        refill(2'd3, 6'd2);
        exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd3);
        start_req(7'd14, 7'd0);
        wait_done(lat, e, s, r);
        check("t4_lat", 32'(lat), 32'd8);
        check("t4_err", 32'(e), 32'd0);
        check("t4_short", 32'(s), 32'd1);
        check("t4_rem", 32'(r), 32'd2);
        @(posedge clk); #1;
        check("t4_empty", 32'(stock_empty), 32'hF);

        // back-pressure: hold ready low, poke change_req while busy
        refill(2'd2, 6'd1);
        exp_q.push_back(2'd2);
        coin_ready = 1'b0;
        start_req(7'd5, 7'd0);
        wait_valid(ok);
        check("t5_valid_seen", 32'(ok), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("t5_hold_valid", 32'(coin_valid), 32'd1);
            check("t5_hold_sel", 32'(coin_sel), 32'd2);
            change_req = (k == 2);
            total_currency = 7'd50;
            item_price = 7'd0;
            @(posedge clk); #1;
        end
        change_req = 1'b0;
        coin_ready = 1'b1;
        wait_done(lat, e, s, r);
        check("t5_done_seen", 32'(lat > 0), 32'd1);
        check("t5_short", 32'(s), 32'd0);
        check("t5_rem", 32'(r), 32'd0);
        repeat (3) @(posedge clk); #1;
        check("t5_ignored_req", 32'(change_busy), 32'd0);
        check("t5_empty", 32'(stock_empty), 32'hF);

        // saturation with simultaneous refill and payout on tube 0
        do_reset();
        refill(2'd0, 6'd63);
        exp_q.push_back(2'd0);
        coin_ready = 1'b0;
        start_req(7'd25, 7'd0);
        wait_valid(ok);
        check("t6_valid_seen", 32'(ok), 32'd1);
        refill_valid = 1'b1; refill_sel = 2'd0; refill_count = 6'd5; coin_ready = 1'b1;
        @(posedge clk); #1;
        refill_valid = 1'b0;
        wait_done(lat, e, s, r);
        check("t6_short", 32'(s), 32'd0);
        @(posedge clk); #1;
        // a saturated tube (63) pays four more 25s; a wrapped count would not
        for (int k = 0; k < 4; k++) exp_q.push_back(2'd0);
        start_req(7'd100, 7'd0);
        wait_done(lat, e, s, r);
        check("t6_lat", 32'(lat), 32'd10);
        check("t6_sat_short", 32'(s), 32'd0);
        check("t6_sat_rem", 32'(r), 32'd0);
        @(posedge clk); #1;
        check("t6_empty", 32'(stock_empty), 32'hE);

        // reset while a coin is presented
        refill(2'd2, 6'd1);
        coin_ready = 1'b0;
        start_req(7'd5, 7'd0);
        wait_valid(ok);
        check("t7_valid_seen", 32'(ok), 32'd1);
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t7_valid", 32'(coin_valid), 32'd0);
        check("t7_busy", 32'(change_busy), 32'd0);
        check("t7_done", 32'(change_done), 32'd0);
        check("t7_empty", 32'(stock_empty), 32'hF);
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("t7_no_done", 32'(done_cnt - d0), 32'd0);
        coin_ready = 1'b1;

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
